ocm_arbiter: RTL and testbench

- Two-master round-robin arbiter sharing one single-port on-chip memory (32-bit data, 1024 words, byte enables, one-cycle read latency, output unregistered).
- Sits between two Avalon-MM masters (e.g. CPU data port and a DMA) and the memory slave port.
- Issues at most one access per cycle.
- Returns read data to the owning master with readdatavalid.

---
 rtl/ocm_arbiter_if.sv | 22 ++
 rtl/ocm_arbiter.sv | 63 ++++++
 tb/tb_ocm_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ocm_arbiter_if.sv
// ocm_arbiter_if: Avalon-MM master port bundle shared by the arbiter and its masters
interface ocm_arbiter_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   address;
   logic                read;
   logic                write;
   logic [DATA_W/8-1:0] byteenable;
   logic [DATA_W-1:0]   writedata;
   logic                waitrequest;
   logic [DATA_W-1:0]   readdata;
   logic                readdatavalid;
   modport master (
      output address, read, write, byteenable, writedata,
      input  waitrequest, readdata, readdatavalid
   );
   modport slave (
      input  address, read, write, byteenable, writedata,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/ocm_arbiter.sv
// ocm_arbiter: two-master round-robin arbiter in front of a single-port one-cycle-latency memory
module ocm_arbiter #(
   parameter int ADDR_W       = 10,
   parameter int DATA_W       = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic                clk,
   input  logic                reset_n,
   ocm_arbiter_if.slave        m0,
   ocm_arbiter_if.slave        m1,
   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W/8-1:0] mem_byteenable,
   output logic [DATA_W-1:0]   mem_writedata,
   output logic                mem_chipselect,
   output logic                mem_write,
   output logic                mem_debugaccess,
   output logic                mem_clken,
   input  logic [DATA_W-1:0]   mem_readdata
);
   // the read-return pipeline is a single stage, so it only ever tracks a latency-1 memory
   localparam logic LAT_OK = (READ_LATENCY == 1);
   logic req0, req1, gnt0, gnt1, any_gnt, gnt_wr, vld0, vld1;
   logic last_grant_d, last_grant_q, rd_pend_d, rd_pend_q, rd_owner_d, rd_owner_q;
   assign mem_clken = 1'b1;
   // grant selection, memory mux, stall generation and read-return steering
   always_comb begin
      req0            = m0.read | m0.write;
      req1            = m1.read | m1.write;
      gnt0            = reset_n & req0 & (~req1 | last_grant_q);
      gnt1            = reset_n & req1 & (~req0 | ~last_grant_q);
      any_gnt         = gnt0 | gnt1;
      gnt_wr          = gnt1 ? m1.write : (gnt0 & m0.write);
      mem_address     = gnt1 ? m1.address : m0.address;
      mem_byteenable  = gnt1 ? m1.byteenable : m0.byteenable;
      mem_writedata   = gnt1 ? m1.writedata : m0.writedata;
      mem_chipselect  = any_gnt;
      mem_write       = gnt_wr;
      mem_debugaccess = gnt_wr;
      m0.waitrequest  = ~reset_n | (req0 & ~gnt0);
      m1.waitrequest  = ~reset_n | (req1 & ~gnt1);
      last_grant_d    = any_gnt ? gnt1 : last_grant_q;
      rd_pend_d       = LAT_OK & any_gnt & ~gnt_wr;
      rd_owner_d      = any_gnt ? gnt1 : rd_owner_q;
      vld0            = rd_pend_q & ~rd_owner_q;
      vld1            = rd_pend_q & rd_owner_q;
      m0.readdatavalid = vld0;
      m1.readdatavalid = vld1;
      m0.readdata     = vld0 ? mem_readdata : '0;
      m1.readdata     = vld1 ? mem_readdata : '0;
   end
   // round-robin pointer and outstanding-read tracking; reset drops any pending read
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant_q <= 1'b1;
         rd_pend_q    <= 1'b0;
         rd_owner_q   <= 1'b0;
      end else begin
         last_grant_q <= last_grant_d;
         rd_pend_q    <= rd_pend_d;
         rd_owner_q   <= rd_owner_d;
      end
   end
endmodule

// File: tb/tb_ocm_arbiter.sv
// tb_ocm_arbiter: directed checks of arbitration, read return, byte enables and reset behaviour
module tb_ocm_arbiter;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [9:0]  mem_address;
   logic [3:0]  mem_byteenable;
   logic [31:0] mem_writedata, mem_readdata;
   logic        mem_chipselect, mem_write, mem_debugaccess, mem_clken;
   logic [31:0] mem [0:1023];
   int          checks = 0;
   int          failures = 0;
   ocm_arbiter_if #(.ADDR_W(10), .DATA_W(32)) m0_if ();
   ocm_arbiter_if #(.ADDR_W(10), .DATA_W(32)) m1_if ();
   ocm_arbiter #(.ADDR_W(10), .DATA_W(32), .READ_LATENCY(1)) dut (
      .clk(clk), .reset_n(reset_n), .m0(m0_if), .m1(m1_if),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
      .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_debugaccess(mem_debugaccess),
      .mem_clken(mem_clken), .mem_readdata(mem_readdata)
   );
   always #5 clk = ~clk;
   // behavioural single-port memory: byte-lane writes, one-cycle read latency
   always @(posedge clk) begin
      if (mem_chipselect && mem_clken) begin
         if (mem_write && mem_debugaccess) begin
            for (int b = 0; b < 4; b++)
               if (mem_byteenable[b]) mem[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
         end else begin
            mem_readdata <= mem[mem_address];
         end
      end
   end
   task automatic m0_set(input logic rd, input logic wr, input logic [9:0] a, input logic [3:0] be, input logic [31:0] wd);
      m0_if.read = rd; m0_if.write = wr; m0_if.address = a; m0_if.byteenable = be; m0_if.writedata = wd;
   endtask
   task automatic m1_set(input logic rd, input logic wr, input logic [9:0] a, input logic [3:0] be, input logic [31:0] wd);
      m1_if.read = rd; m1_if.write = wr; m1_if.address = a; m1_if.byteenable = be; m1_if.writedata = wd;
   endtask
   task automatic idle();
      m0_set(0, 0, 0, 0, 0);
      m1_set(0, 0, 0, 0, 0);
   endtask
   task automatic apply_reset();
      @(negedge clk); idle(); reset_n = 1'b0;
      @(negedge clk); reset_n = 1'b1;
   endtask
   task automatic test_reset();
      idle();
      m0_set(1, 0, 4, 4'hF, 0);
      #2;
      checks++; if (m0_if.waitrequest !== 1'b1) begin failures++; $display("FAIL rst_m0_wait act=%0h exp=1", m0_if.waitrequest); end
      checks++; if (m1_if.waitrequest !== 1'b1) begin failures++; $display("FAIL rst_m1_wait act=%0h exp=1", m1_if.waitrequest); end
      checks++; if (mem_chipselect !== 1'b0) begin failures++; $display("FAIL rst_cs act=%0h exp=0", mem_chipselect); end
      checks++; if ({m0_if.readdatavalid, m1_if.readdatavalid} !== 2'b00) begin failures++; $display("FAIL rst_valid act=%0b exp=00", {m0_if.readdatavalid, m1_if.readdatavalid}); end
      checks++; if (m0_if.readdata !== 32'h0) begin failures++; $display("FAIL rst_rdata act=%0h exp=0", m0_if.readdata); end
      @(negedge clk); idle(); reset_n = 1'b1;
   endtask
   task automatic test_write_read();
      @(negedge clk); idle(); m0_set(0, 1, 5, 4'hF, 32'hDEADBEEF); #1;
      checks++; if (m0_if.waitrequest !== 1'b0) begin failures++; $display("FAIL wr_m0_wait act=%0h exp=0", m0_if.waitrequest); end
      checks++; if (mem_write !== 1'b1 || mem_address !== 10'd5) begin failures++; $display("FAIL wr_mem act=%0h/%0h exp=1/5", mem_write, mem_address); end
      @(negedge clk); m0_set(1, 0, 5, 4'hF, 0); #1;
      checks++; if ({m0_if.waitrequest, m1_if.waitrequest} !== 2'b00) begin failures++; $display("FAIL rd_wait act=%0b exp=00", {m0_if.waitrequest, m1_if.waitrequest}); end
      checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL rd_mem_write act=%0h exp=0", mem_write); end
      @(negedge clk); idle(); #1;
      checks++; if (m0_if.readdatavalid !== 1'b1 || m0_if.readdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_m0_data act=%0h/%0h exp=1/deadbeef", m0_if.readdatavalid, m0_if.readdata); end
      checks++; if (m1_if.readdatavalid !== 1'b0) begin failures++; $display("FAIL rd_m1_valid act=%0h exp=0", m1_if.readdatavalid); end
   endtask
   task automatic test_alternate();
      logic [31:0] exp_d;
      @(negedge clk); idle(); m0_set(0, 1, 1, 4'hF, 32'h11110001);
      @(negedge clk); idle(); m1_set(0, 1, 2, 4'hF, 32'h22220002);
      @(negedge clk); m0_set(1, 0, 1, 4'hF, 0); m1_set(1, 0, 2, 4'hF, 0);
      for (int i = 0; i < 6; i++) begin
         #1;
         checks++; if (m0_if.waitrequest !== (i % 2 == 1) || m1_if.waitrequest !== (i % 2 == 0)) begin failures++; $display("FAIL alt_wait_%0d act=%0b%0b", i, m0_if.waitrequest, m1_if.waitrequest); end
         if (i > 0) begin
            exp_d = (i % 2 == 1) ? 32'h11110001 : 32'h22220002;
            checks++; if (m0_if.readdatavalid !== (i % 2 == 1) || m1_if.readdatavalid !== (i % 2 == 0)) begin failures++; $display("FAIL alt_valid_%0d act=%0b%0b", i, m0_if.readdatavalid, m1_if.readdatavalid); end
            checks++; if ((m0_if.readdata | m1_if.readdata) !== exp_d) begin failures++; $display("FAIL alt_data_%0d act=%0h exp=%0h", i, m0_if.readdata | m1_if.readdata, exp_d); end
         end
         @(negedge clk);
      end
      idle(); #1;
      checks++; if (m1_if.readdatavalid !== 1'b1 || m1_if.readdata !== 32'h22220002 || m0_if.readdatavalid !== 1'b0) begin failures++; $display("FAIL alt_last act=%0h/%0h exp=1/22220002", m1_if.readdatavalid, m1_if.readdata); end
   endtask
   task automatic test_byte_enable();
      @(negedge clk); idle(); m1_set(0, 1, 1023, 4'hF, 32'hFFFFFFFF);
      @(negedge clk); m1_set(0, 1, 1023, 4'b0101, 32'h11223344); #1;
      checks++; if (m1_if.waitrequest !== 1'b0 || mem_byteenable !== 4'b0101) begin failures++; $display("FAIL be_wr act=%0h/%0h exp=0/5", m1_if.waitrequest, mem_byteenable); end
      @(negedge clk); m1_set(1, 0, 1023, 4'hF, 0);
      @(negedge clk); idle(); #1;
      checks++; if (m1_if.readdatavalid !== 1'b1 || m1_if.readdata !== 32'hFF22FF44) begin failures++; $display("FAIL be_data act=%0h/%0h exp=1/ff22ff44", m1_if.readdatavalid, m1_if.readdata); end
   endtask
   task automatic test_contention();
      apply_reset();
      m0_set(0, 1, 7, 4'hF, 32'hA5A5A5A5); m1_set(1, 0, 7, 4'hF, 0); #1;
      checks++; if (m0_if.waitrequest !== 1'b0 || m1_if.waitrequest !== 1'b1) begin failures++; $display("FAIL con_wait act=%0b%0b exp=01", m0_if.waitrequest, m1_if.waitrequest); end
      checks++; if (mem_write !== 1'b1 || mem_address !== 10'd7) begin failures++; $display("FAIL con_mem act=%0h/%0h exp=1/7", mem_write, mem_address); end
      @(negedge clk); m0_set(0, 0, 0, 0, 0); #1;
      checks++; if (m1_if.waitrequest !== 1'b0 || mem_write !== 1'b0 || m0_if.readdatavalid !== 1'b0) begin failures++; $display("FAIL con_m1_grant act=%0h/%0h/%0h exp=0/0/0", m1_if.waitrequest, mem_write, m0_if.readdatavalid); end
      @(negedge clk); idle(); #1;
      checks++; if (m1_if.readdatavalid !== 1'b1 || m1_if.readdata !== 32'hA5A5A5A5 || m0_if.readdatavalid !== 1'b0) begin failures++; $display("FAIL con_data act=%0h/%0h exp=1/a5a5a5a5", m1_if.readdatavalid, m1_if.readdata); end
   endtask
   task automatic test_reset_mid_read();
      @(negedge clk); idle(); m1_set(1, 0, 7, 4'hF, 0); #1;
      checks++; if (m1_if.waitrequest !== 1'b0) begin failures++; $display("FAIL mr_accept act=%0h exp=0", m1_if.waitrequest); end
      @(posedge clk); #1 reset_n = 1'b0;
      m0_set(1, 0, 1, 4'hF, 0); m1_set(1, 0, 2, 4'hF, 0); #1;
      checks++; if (m1_if.readdatavalid !== 1'b0 || m1_if.readdata !== 32'h0) begin failures++; $display("FAIL mr_valid act=%0h/%0h exp=0/0", m1_if.readdatavalid, m1_if.readdata); end
      checks++; if ({m0_if.waitrequest, m1_if.waitrequest} !== 2'b11 || mem_chipselect !== 1'b0) begin failures++; $display("FAIL mr_wait act=%0b/%0h exp=11/0", {m0_if.waitrequest, m1_if.waitrequest}, mem_chipselect); end
      @(negedge clk); @(negedge clk); #1;
      checks++; if (m1_if.readdatavalid !== 1'b0) begin failures++; $display("FAIL mr_valid_late act=%0h exp=0", m1_if.readdatavalid); end
      reset_n = 1'b1; #1;
      checks++; if (m0_if.waitrequest !== 1'b0 || m1_if.waitrequest !== 1'b1) begin failures++; $display("FAIL mr_first_grant act=%0b%0b exp=01", m0_if.waitrequest, m1_if.waitrequest); end
      @(negedge clk); idle(); #1;
      checks++; if (m0_if.readdatavalid !== 1'b1 || m0_if.readdata !== 32'h11110001 || m1_if.readdatavalid !== 1'b0) begin failures++; $display("FAIL mr_data act=%0h/%0h exp=1/11110001", m0_if.readdatavalid, m0_if.readdata); end
   endtask
   task automatic test_read_write_both();
      @(negedge clk); idle(); m0_set(1, 1, 3, 4'hF, 32'h5); #1;
      checks++; if (mem_write !== 1'b1 || mem_debugaccess !== 1'b1 || m0_if.waitrequest !== 1'b0) begin failures++; $display("FAIL rw_write act=%0h/%0h/%0h exp=1/1/0", mem_write, mem_debugaccess, m0_if.waitrequest); end
      @(negedge clk); m0_set(1, 0, 3, 4'hF, 0); #1;
      checks++; if (m0_if.readdatavalid !== 1'b0) begin failures++; $display("FAIL rw_no_valid act=%0h exp=0", m0_if.readdatavalid); end
      @(negedge clk); idle(); #1;
      checks++; if (m0_if.readdatavalid !== 1'b1 || m0_if.readdata !== 32'h5) begin failures++; $display("FAIL rw_data act=%0h/%0h exp=1/5", m0_if.readdatavalid, m0_if.readdata); end
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end
   initial begin
      test_reset();
      test_write_read();
      test_alternate();
      test_byte_enable();
      test_contention();
      test_reset_mid_read();
      test_read_write_both();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
